fact_ctrl_unit: RTL

- Control FSM that drives the factorial datapath: generates sel1, sel2, Load_cnt, Load_reg and EN, and consumes the datapath status lines compared and error.
- Provides a go/done start–finish handshake to the top level, plus an iteration watchdog.
- Sits beside the factorial datapath inside the factorial top. Product data never passes through this block; only control and status signals do.

---
 rtl/fact_ctrl_if.sv | 28 ++
 rtl/fact_ctrl_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/fact_ctrl_if.sv
// Control/status bundle between the factorial controller and its surroundings:
// start/finish handshake, datapath strobes and datapath status lines.
interface fact_ctrl_if;
    logic       go;
    logic       compared;
    logic       error;
    logic       sel1;
    logic       sel2;
    logic       Load_cnt;
    logic       Load_reg;
    logic       EN;
    logic       done;
    logic       err;
    logic       busy;
    logic [2:0] cs;

    // Top level / datapath side
    modport master (
        output go, compared, error,
        input  sel1, sel2, Load_cnt, Load_reg, EN, done, err, busy, cs
    );

    // Controller side
    modport slave (
        input  go, compared, error,
        output sel1, sel2, Load_cnt, Load_reg, EN, done, err, busy, cs
    );
endinterface

// File: rtl/fact_ctrl_unit.sv
// Moore control FSM for the factorial datapath: sequences load / multiply /
// check steps, runs a go/done four-phase handshake and bounds the MUL count.
module fact_ctrl_unit #(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    fact_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_e              state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [ITER_W-1:0]   iter_inc;

    assign iter_inc = iter_q + ITER_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                iter_d = '0;
                if (bus.go) state_d = S_LOAD;
            end
            // Range error wins over the normal path to CHECK.
            S_LOAD: begin
                if (bus.error) state_d = S_ERR;
                else           state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.compared) state_d = S_MUL;
                else              state_d = S_DONE;
            end
            // Watchdog: the MUL that brings iter to MAX_ITER aborts the run.
            S_MUL: begin
                iter_d = iter_inc;
                if (iter_inc == MAX_ITER_C) state_d = S_ERR;
                else                        state_d = S_CHECK;
            end
            S_DONE: begin
                if (!bus.go) state_d = S_IDLE;
            end
            S_ERR: begin
                if (!bus.go) state_d = S_IDLE;
            end
            // Unused codes 6/7 recover to IDLE.
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.sel1     = 1'b0;
        bus.sel2     = 1'b0;
        bus.Load_cnt = 1'b0;
        bus.Load_reg = 1'b0;
        bus.EN       = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.busy     = 1'b0;
        case (state_q)
            S_LOAD: begin
                bus.Load_cnt = 1'b1;
                bus.Load_reg = 1'b1;
                bus.busy     = 1'b1;
            end
            S_CHECK: begin
                bus.busy     = 1'b1;
            end
            S_MUL: begin
                bus.sel1     = 1'b1;
                bus.Load_reg = 1'b1;
                bus.EN       = 1'b1;
                bus.busy     = 1'b1;
            end
            S_DONE: begin
                bus.done     = 1'b1;
                bus.sel2     = 1'b1;
            end
            S_ERR: begin
                bus.err      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cs = state_q;

endmodule
